lfsr_rng_arbiter: RTL and testbench
===================================

LFSR_RNG_ARBITER -- requirements
Module: lfsr_rng_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter LOAD_CYCLES, default 2, giving the number of cycles the LFSR load is held (1..15).
REQ-003 The block SHALL have parameter WARM_CYCLES, default 4, giving the number of LFSR outputs discarded after each seed load (0..15).
REQ-004 The block SHALL have parameter SEED_DEFAULT, default 8'h88, giving the seed used after reset.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, the reset, which is synchronous and active-high.
REQ-007 The block SHALL have port req, input, NREQ, with one level request per requester.
REQ-008 The block SHALL have port gnt, output, NREQ, a one-hot grant pulse lasting one cycle.
REQ-009 The block SHALL have port rnd_data, output, 8, the random byte delivered with gnt.
REQ-010 The block SHALL have port rnd_valid, output, 1, high exactly when any gnt bit is high.
REQ-011 The block SHALL have ports seed_wr (input, 1) and seed_in (input, 8), a seed write strobe and its seed value.
REQ-012 The block SHALL have port busy, output, 1, high in every state except READY.
REQ-013 The block SHALL have ports lfsr_rst_n (output, 1), lfsr_load (output, 1) and lfsr_seed (output, 8), driving the external 8-bit LFSR.
REQ-014 The block SHALL have port lfsr_q, input, 8, the LFSR state; the LFSR advances every clock when not loading.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, SEEDING, WARMUP and READY.
REQ-016 IDLE SHALL move to SEEDING on the next cycle, using the pending seed.
REQ-017 SEEDING SHALL drive lfsr_rst_n=0, lfsr_load=1 and lfsr_seed=pending seed for exactly LOAD_CYCLES cycles, then move to WARMUP.
REQ-018 WARMUP SHALL drive lfsr_rst_n=1 and lfsr_load=0, count WARM_CYCLES cycles (0 means go straight on), then move to READY.
REQ-019 In READY, each cycle with req!=0 SHALL register exactly one grant, chosen round-robin starting from the index after the last granted requester (index 0 first after reset).
REQ-020 gnt, rnd_valid and rnd_data SHALL be registered, appearing one cycle after the sampled req, with rnd_data equal to lfsr_q in the sampling cycle.
REQ-021 A requester holding req high SHALL be granted again only after every other active requester has been granted once.
REQ-022 No grant SHALL be issued in IDLE, SEEDING or WARMUP; requests made then SHALL wait and never be dropped.
REQ-023 seed_wr in READY SHALL latch seed_in as the pending seed and move to SEEDING on the next cycle; a request sampled in that same cycle is not granted.
REQ-024 seed_wr in SEEDING or WARMUP SHALL latch the new seed and restart SEEDING with a full LOAD_CYCLES count.
REQ-025 The round-robin pointer SHALL be kept across reseeds.
REQ-026 The cycle counters SHALL be 4 bits wide and SHALL NOT wrap; they saturate at their terminal count.

Reset
REQ-027 While rst is high on a rising edge, the block SHALL enter IDLE with pending seed=SEED_DEFAULT and round-robin pointer=0.
REQ-028 During reset, outputs SHALL be gnt=0, rnd_valid=0, rnd_data=8'h00, busy=1, lfsr_rst_n=0, lfsr_load=0 and lfsr_seed=SEED_DEFAULT.
REQ-029 Reset asserted in any state, including mid-SEEDING, SHALL abandon the sequence; no grant is issued in the cycle after reset.

Configuration
REQ-030 When RNG_ARB_ZERO_GUARD_EN is defined, a seed_in of 8'h00 SHALL be replaced by SEED_DEFAULT when latched.
REQ-031 When RNG_ARB_ZERO_GUARD_EN is defined, lfsr_q==8'h00 in READY SHALL suppress that cycle's grant and force a reseed with SEED_DEFAULT.
REQ-032 When RNG_ARB_ZERO_GUARD_EN is undefined, 8'h00 seeds and outputs SHALL be passed through unchanged, and no grant is suppressed.

Verification
REQ-033 Bench SHALL check: reset released with defaults -> busy=1 for 1+2+4 cycles, lfsr_load=1 for 2 cycles with lfsr_seed=8'h88, then busy=0.
REQ-034 Bench SHALL check: req=4'b1111 held in READY -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles, rnd_data matching lfsr_q one cycle earlier.
REQ-035 Bench SHALL check: req=4'b0101 -> gnt alternates 0001/0100, and rnd_valid is never high with gnt=0.
REQ-036 Bench SHALL check: seed_wr with seed_in=8'h12 in READY, then seed_wr with 8'hE4 during WARMUP -> SEEDING restarts with lfsr_seed=8'hE4 for a full 2 cycles, and no grants occur until READY.
REQ-037 Bench SHALL check: seed_in=8'h00 -> with RNG_ARB_ZERO_GUARD_EN, lfsr_seed=8'h88; without it, lfsr_seed=8'h00 and grants return rnd_data=8'h00.
REQ-038 Bench SHALL check: rst pulsed for 1 cycle mid-SEEDING with req=4'b0010 held -> state IDLE, gnt=0, and the first grant after the reseed is 4'b0001 only if req[0] is also high, else 4'b0010.

Source files
------------

// File: rtl/lfsr_rng_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : lfsr_rng_arbiter
// Purpose  : Round-robin arbiter that hands out bytes from an external 8-bit LFSR,
//            sequencing the LFSR seed load and warm-up before granting.
// Options  : RNG_ARB_ZERO_GUARD_EN - replace zero seeds and reseed on a zero LFSR state
// Revision : 1.0 - initial release
//==============================================================================
module lfsr_rng_arbiter #(
  parameter int         NREQ         = 4,
  parameter int         LOAD_CYCLES  = 2,
  parameter int         WARM_CYCLES  = 4,
  parameter logic [7:0] SEED_DEFAULT = 8'h88
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [7:0]      rnd_data,
  output logic            rnd_valid,
  input  logic            seed_wr,
  input  logic [7:0]      seed_in,
  output logic            busy,
  output logic            lfsr_rst_n,
  output logic            lfsr_load,
  output logic [7:0]      lfsr_seed,
  input  logic [7:0]      lfsr_q
);

  localparam int         c_PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] c_LOAD_LAST = 4'(LOAD_CYCLES - 1);
  localparam logic [3:0] c_WARM_LAST = 4'((WARM_CYCLES > 0) ? (WARM_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEEDING = 2'd1,
    S_WARMUP  = 2'd2,
    S_READY   = 2'd3
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [7:0]        r_seed;
  logic [c_PW-1:0]   r_ptr;
  logic [NREQ-1:0]   r_gnt;
  logic [7:0]        r_rnd_data;
  logic              r_rnd_valid;
  logic              r_busy;
  logic              r_lfsr_rst_n;
  logic              r_lfsr_load;
  logic [7:0]        r_lfsr_seed;

  logic [7:0]        w_seed_g;
  logic              w_zero_kill;
  logic [7:0]        w_reseed_val;
  logic [c_PW-1:0]   w_scan;
  logic [c_PW-1:0]   w_idx;
  logic [c_PW-1:0]   w_next_ptr;
  logic              w_hit;

`ifdef RNG_ARB_ZERO_GUARD_EN
  assign w_seed_g    = (seed_in == 8'h00) ? SEED_DEFAULT : seed_in;
  assign w_zero_kill = (lfsr_q == 8'h00);
`else
  assign w_seed_g    = seed_in;
  assign w_zero_kill = 1'b0;
`endif

  assign w_reseed_val = seed_wr ? w_seed_g : SEED_DEFAULT;

  // Scan downwards so the requester closest after the pointer wins.
  always_comb begin
    w_idx  = '0;
    w_hit  = 1'b0;
    w_scan = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_scan = c_PW'((int'(r_ptr) + k) % NREQ);
      if (req[w_scan]) begin
        w_idx = w_scan;
        w_hit = 1'b1;
      end
    end
  end

  assign w_next_ptr = (w_idx == c_PW'(NREQ - 1)) ? '0 : (w_idx + 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_seed       <= SEED_DEFAULT;
      r_ptr        <= '0;
      r_gnt        <= '0;
      r_rnd_data   <= 8'h00;
      r_rnd_valid  <= 1'b0;
      r_busy       <= 1'b1;
      r_lfsr_rst_n <= 1'b0;
      r_lfsr_load  <= 1'b0;
      r_lfsr_seed  <= SEED_DEFAULT;
    end else begin
      r_gnt       <= '0;
      r_rnd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state      <= S_SEEDING;
          r_cnt        <= '0;
          r_busy       <= 1'b1;
          r_lfsr_rst_n <= 1'b0;
          r_lfsr_load  <= 1'b1;
          r_lfsr_seed  <= r_seed;
        end
        S_SEEDING: begin
          if (seed_wr) begin
            r_seed      <= w_seed_g;
            r_lfsr_seed <= w_seed_g;
            r_cnt       <= '0;
          end else if (r_cnt == c_LOAD_LAST) begin
            r_cnt        <= '0;
            r_lfsr_load  <= 1'b0;
            r_lfsr_rst_n <= 1'b1;
            if (WARM_CYCLES == 0) begin
              r_state <= S_READY;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_WARMUP;
            end
          end else if (r_cnt != 4'hF) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WARMUP: begin
          if (seed_wr) begin
            r_state      <= S_SEEDING;
            r_seed       <= w_seed_g;
            r_lfsr_seed  <= w_seed_g;
            r_cnt        <= '0;
            r_lfsr_load  <= 1'b1;
            r_lfsr_rst_n <= 1'b0;
          end else if (r_cnt == c_WARM_LAST) begin
            r_cnt   <= '0;
            r_state <= S_READY;
            r_busy  <= 1'b0;
          end else if (r_cnt != 4'hF) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_READY: begin
          // A reseed takes priority over any request sampled in the same cycle.
          if (seed_wr || w_zero_kill) begin
            r_state      <= S_SEEDING;
            r_seed       <= w_reseed_val;
            r_lfsr_seed  <= w_reseed_val;
            r_cnt        <= '0;
            r_busy       <= 1'b1;
            r_lfsr_load  <= 1'b1;
            r_lfsr_rst_n <= 1'b0;
          end else if (w_hit) begin
            r_gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << w_idx;
            r_rnd_valid <= 1'b1;
            r_rnd_data  <= lfsr_q;
            r_ptr       <= w_next_ptr;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign rnd_data   = r_rnd_data;
  assign rnd_valid  = r_rnd_valid;
  assign busy       = r_busy;
  assign lfsr_rst_n = r_lfsr_rst_n;
  assign lfsr_load  = r_lfsr_load;
  assign lfsr_seed  = r_lfsr_seed;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_rng_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_lfsr_rng_arbiter
// Purpose  : Scoreboard bench for lfsr_rng_arbiter with a behavioural 8-bit LFSR.
// Revision : 1.0 - initial release
//==============================================================================
module tb_lfsr_rng_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [7:0] rnd_data;
  logic       rnd_valid;
  logic       seed_wr;
  logic [7:0] seed_in;
  logic       busy;
  logic       lfsr_rst_n;
  logic       lfsr_load;
  logic [7:0] lfsr_seed;
  logic [7:0] lfsr_q;

  typedef struct packed {
    logic [3:0] g;
    logic [7:0] d;
  } exp_t;

  exp_t  sb_q[$];
  int    checks = 0;
  int    errors = 0;
  int    exp_ptr;
  logic  mon_en;
  string phase;

`ifdef RNG_ARB_ZERO_GUARD_EN
  localparam logic [7:0] c_ZERO_SEED_EXP = 8'h88;
`else
  localparam logic [7:0] c_ZERO_SEED_EXP = 8'h00;
`endif

  lfsr_rng_arbiter #(
    .NREQ(4), .LOAD_CYCLES(2), .WARM_CYCLES(4), .SEED_DEFAULT(8'h88)
  ) u_dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .rnd_data(rnd_data),
    .rnd_valid(rnd_valid), .seed_wr(seed_wr), .seed_in(seed_in), .busy(busy),
    .lfsr_rst_n(lfsr_rst_n), .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed),
    .lfsr_q(lfsr_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External LFSR: x^8+x^6+x^5+x^4+1, cleared while held in reset.
  always @(posedge clk) begin
    if (lfsr_load)        lfsr_q <= lfsr_seed;
    else if (!lfsr_rst_n) lfsr_q <= 8'h00;
    else                  lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s/%s got=%0h exp=%0h", phase, tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int p);
    logic [1:0] j;
    for (int k = 0; k < 4; k++) begin
      j = 2'((p + k) % 4);
      if (r[j]) return int'(j);
    end
    return -1;
  endfunction

  // One clock: push the expected result of this edge, then pop and compare.
  task automatic step_exp(input logic allow);
    exp_t e;
    int   idx;
    e = '0;
    if (allow) begin
      idx = rr_pick(req, exp_ptr);
      if (idx >= 0) begin
        e.g     = 4'b0001 << idx;
        e.d     = lfsr_q;
        exp_ptr = (idx + 1) % 4;
      end
    end
    sb_q.push_back(e);
    tick();
    e = sb_q.pop_front();
    check_val("gnt", gnt, e.g);
    if (e.g != 4'b0000) check_val("rnd_data", rnd_data, e.d);
  endtask

  task automatic wait_seq(input int exp_busy, input int exp_load, input logic [7:0] exp_seed);
    int nb;
    int nl;
    nb = 0;
    nl = 0;
    for (int c = 0; c < 40; c++) begin
      if (!busy) break;
      nb++;
      if (lfsr_load) begin
        nl++;
        check_val("lfsr_seed", lfsr_seed, exp_seed);
      end
      step_exp(1'b0);
    end
    check_val("busy_cycles", nb, exp_busy);
    check_val("load_cycles", nl, exp_load);
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      check_val("valid_vs_gnt", rnd_valid, (gnt != 4'b0000));
      check_val("gnt_onehot0", $onehot0(gnt), 1'b1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rm_req [2];
    logic [3:0] rm_gnt [2];
    rm_req = '{4'b0011, 4'b0010};
    rm_gnt = '{4'b0001, 4'b0010};
    rst = 1'b1; req = 4'b0000; seed_wr = 1'b0; seed_in = 8'h00;
    mon_en = 1'b0; exp_ptr = 0; phase = "reset";
    repeat (3) tick();
    check_val("gnt", gnt, 4'b0000);
    check_val("rnd_valid", rnd_valid, 1'b0);
    check_val("rnd_data", rnd_data, 8'h00);
    check_val("busy", busy, 1'b1);
    check_val("lfsr_rst_n", lfsr_rst_n, 1'b0);
    check_val("lfsr_load", lfsr_load, 1'b0);
    check_val("lfsr_seed", lfsr_seed, 8'h88);
    mon_en = 1'b1;

    phase = "boot";
    rst = 1'b0;
    wait_seq(7, 2, 8'h88);
    check_val("lfsr_rst_n", lfsr_rst_n, 1'b1);

    phase = "rr1111";
    req = 4'b1111;
    repeat (5) step_exp(1'b1);
    check_val("fifth_gnt", gnt, 4'b0001);

    phase = "rr0101";
    req = 4'b0101;
    repeat (6) step_exp(1'b1);

    phase = "reseed";
    req = 4'b1111;
    seed_in = 8'h12; seed_wr = 1'b1;
    step_exp(1'b0);
    seed_wr = 1'b0;
    check_val("load", lfsr_load, 1'b1);
    check_val("seed12", lfsr_seed, 8'h12);
    step_exp(1'b0);
    step_exp(1'b0);
    check_val("warm_busy", busy, 1'b1);
    check_val("warm_load", lfsr_load, 1'b0);
    check_val("warm_rst_n", lfsr_rst_n, 1'b1);
    seed_in = 8'hE4; seed_wr = 1'b1;
    step_exp(1'b0);
    seed_wr = 1'b0;
    wait_seq(6, 2, 8'hE4);
    repeat (4) step_exp(1'b1);

    phase = "zero";
    seed_in = 8'h00; seed_wr = 1'b1;
    step_exp(1'b0);
    seed_wr = 1'b0;
    wait_seq(6, 2, c_ZERO_SEED_EXP);
    repeat (4) step_exp(1'b1);
`ifndef RNG_ARB_ZERO_GUARD_EN
    check_val("zero_data", rnd_data, 8'h00);
`endif

    phase = "rst_mid";
    req = 4'b0001;
    step_exp(1'b1);
    for (int r = 0; r < 2; r++) begin
      req = rm_req[r];
      seed_in = 8'h5A; seed_wr = 1'b1;
      step_exp(1'b0);
      seed_wr = 1'b0;
      check_val("mid_seeding", lfsr_load, 1'b1);
      rst = 1'b1;
      step_exp(1'b0);
      rst = 1'b0;
      check_val("idle_busy", busy, 1'b1);
      check_val("idle_load", lfsr_load, 1'b0);
      check_val("idle_rst_n", lfsr_rst_n, 1'b0);
      check_val("idle_seed", lfsr_seed, 8'h88);
      check_val("idle_valid", rnd_valid, 1'b0);
      exp_ptr = 0;
      wait_seq(7, 2, 8'h88);
      step_exp(1'b1);
      check_val("first_gnt", gnt, rm_gnt[r]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
